// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the controller/ALU datapath.
// Owns the PC, issues word reads to a synchronous instruction memory
// (data returns one cycle after the request), buffers returned words in a
// small prefetch FIFO and hands them downstream with a valid/ready handshake.
// A taken branch (Redirect) reloads the PC and discards every wrong-path word,
// including a response that is still in flight.
// Optional build macro FETCH_PERF_COUNTERS_EN adds StallCycles/FlushCount.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTHC = CW'(DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic          inflight;
  logic [31:0]   inflightpc;
  logic [AW-1:0] rdptr;
  logic [AW-1:0] wrptr;
  logic [31:0]   wordmem [DEPTH];
  logic [31:0]   pcmem   [DEPTH];

  logic [CW-1:0] credit;
  logic [31:0]   target;
  logic          issue;
  logic          push;
  logic          pop;

  // Request credit counts buffered words plus the one in flight, so the FIFO
  // can never overflow; a pop only frees credit once count has updated.
  always_comb begin
    credit     = count + {{(CW-1){1'b0}}, inflight};
    target     = RedirectTarget & 32'hFFFF_FFFC;
    issue      = Rst & ~Redirect & (credit < DEPTHC);
    push       = inflight & ~Redirect;
    InstrValid = (count != '0);
    pop        = InstrValid & InstrReady;
  end

  // Memory request and head-of-FIFO outputs, all from registered state.
  always_comb begin
    IMemReq      = issue;
    IMemAddr     = pc;
    Instruction  = '0;
    InstrPC      = '0;
    InstrPCPlus4 = '0;
    if (InstrValid) begin
      Instruction  = wordmem[rdptr];
      InstrPC      = pcmem[rdptr];
      InstrPCPlus4 = pcmem[rdptr] + 32'd4;
    end
  end

  // PC, in-flight tracking and FIFO occupancy; redirect wins over everything.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc         <= RESET_PC;
      count      <= '0;
      inflight   <= 1'b0;
      inflightpc <= '0;
      rdptr      <= '0;
      wrptr      <= '0;
    end else if (Redirect) begin
      pc       <= target;
      count    <= '0;
      inflight <= 1'b0;
      rdptr    <= '0;
      wrptr    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc         <= pc + 32'd4;
        inflightpc <= pc;
      end
      if (push) wrptr <= wrptr + 1'b1;
      if (pop)  rdptr <= rdptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: returned word tagged with the address it was fetched from.
  always_ff @(posedge Clk) begin
    if (push) begin
      wordmem[wrptr] <= IMemRdata;
      pcmem[wrptr]   <= inflightpc;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Count downstream back-pressure cycles and pipeline flushes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (InstrValid & ~InstrReady) StallCycles <= StallCycles + 32'd1;
      if (Redirect)                 FlushCount  <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit.
// Two instances share clock and reset: dutMain starts at PC 0, dutWrap starts
// at 32'hFFFF_FFF8 to exercise PC wrap-around. Each memory returns
// 32'h1000_0000 + word index one cycle after the request.

module tb_instr_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRdata;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic [31:0] InstrPCPlus4;
  logic        InstrValid;
  logic        InstrReady;

  logic        bReq;
  logic [31:0] bAddr;
  logic [31:0] bRdata;
  logic        bRedirect;
  logic [31:0] bTarget;
  logic [31:0] bInstr;
  logic [31:0] bPC;
  logic [31:0] bPCPlus4;
  logic        bValid;
  logic        bReady;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCount;
  logic [31:0] bStallCycles;
  logic [31:0] bFlushCount;
`endif

  int testsRun;
  int testsFailed;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dutMain (
    .Clk            (Clk),
    .Rst            (Rst),
    .IMemReq        (IMemReq),
    .IMemAddr       (IMemAddr),
    .IMemRdata      (IMemRdata),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Instruction    (Instruction),
    .InstrPC        (InstrPC),
    .InstrPCPlus4   (InstrPCPlus4),
    .InstrValid     (InstrValid),
    .InstrReady     (InstrReady)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .StallCycles    (stallCycles),
    .FlushCount     (flushCount)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dutWrap (
    .Clk            (Clk),
    .Rst            (Rst),
    .IMemReq        (bReq),
    .IMemAddr       (bAddr),
    .IMemRdata      (bRdata),
    .Redirect       (bRedirect),
    .RedirectTarget (bTarget),
    .Instruction    (bInstr),
    .InstrPC        (bPC),
    .InstrPCPlus4   (bPCPlus4),
    .InstrValid     (bValid),
    .InstrReady     (bReady)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .StallCycles    (bStallCycles),
    .FlushCount     (bFlushCount)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  // Synchronous instruction memories: data valid the cycle after the request.
  always @(posedge Clk) begin
    if (IMemReq) IMemRdata <= memWord(IMemAddr);
    if (bReq)    bRdata    <= memWord(bAddr);
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic expectReq(input string tag, input logic [31:0] addr);
    checkOutput({tag, "_req"}, 32'(IMemReq), 32'd1);
    checkOutput({tag, "_addr"}, IMemAddr, addr);
  endtask

  task automatic expectNoReq(input string tag);
    checkOutput({tag, "_noreq"}, 32'(IMemReq), 32'd0);
  endtask

  task automatic expectEmpty(input string tag);
    checkOutput({tag, "_valid"}, 32'(InstrValid), 32'd0);
  endtask

  task automatic expectHead(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pcPlus4);
    checkOutput({tag, "_valid"}, 32'(InstrValid), 32'd1);
    checkOutput({tag, "_instr"}, Instruction, instr);
    checkOutput({tag, "_pc"}, InstrPC, pc);
    checkOutput({tag, "_pc4"}, InstrPCPlus4, pcPlus4);
  endtask

  task automatic applyStimulus(input int step);
    InstrReady     = ((step >= 10) && (step <= 17)) || ((step >= 20) && (step <= 26));
    Redirect       = (step == 19) || (step == 24);
    RedirectTarget = (step == 19) ? 32'h0000_0103 :
                     (step == 24) ? 32'h0000_0202 : 32'h0000_0000;
  endtask

  logic [31:0] wrapAddr [5];
  logic [31:0] wrapInstr [3];
  logic [31:0] wrapPC [3];
  logic [31:0] wrapPC4 [3];

  initial begin
    string tag;
    testsRun       = 0;
    testsFailed    = 0;
    Redirect       = 1'b0;
    RedirectTarget = '0;
    InstrReady     = 1'b1;
    bRedirect      = 1'b0;
    bTarget        = '0;
    bReady         = 1'b1;
    wrapAddr  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    wrapInstr = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
    wrapPC    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    wrapPC4   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Initial reset: everything quiet.
    Rst = 1'b1;
    #1 Rst = 1'b0;
    #2;
    expectNoReq("rst");
    expectEmpty("rst");
    checkOutput("rst_instr", Instruction, 32'd0);
    checkOutput("rst_pc", InstrPC, 32'd0);
    checkOutput("rst_pc4", InstrPCPlus4, 32'd0);
    checkOutput("rst_wrap_req", 32'(bReq), 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput("rst_stall", stallCycles, 32'd0);
    checkOutput("rst_flush", flushCount, 32'd0);
`endif

    // Streaming from reset with InstrReady high; wrap instance alongside.
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      if (i == 0) Rst = 1'b1;
      #1;
      tag = $sformatf("C%0d", i);
      expectReq(tag, 32'(4 * i));
      if (i < 2) expectEmpty(tag);
      else expectHead(tag, 32'h1000_0000 + 32'(i - 2), 32'(4 * (i - 2)), 32'(4 * (i - 1)));
      if (i < 5) begin
        checkOutput({tag, "_wrap_req"}, 32'(bReq), 32'd1);
        checkOutput({tag, "_wrap_addr"}, bAddr, wrapAddr[i]);
      end
      if ((i >= 2) && (i < 5)) begin
        checkOutput({tag, "_wrap_valid"}, 32'(bValid), 32'd1);
        checkOutput({tag, "_wrap_instr"}, bInstr, wrapInstr[i - 2]);
        checkOutput({tag, "_wrap_pc"}, bPC, wrapPC[i - 2]);
        checkOutput({tag, "_wrap_pc4"}, bPCPlus4, wrapPC4[i - 2]);
      end
    end

    // Reset again, then back-pressure, drain, redirects and a full FIFO.
    Rst        = 1'b0;
    InstrReady = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      nextCycle();
      if (i == 0) Rst = 1'b1;
      applyStimulus(i);
      #1;
      tag = $sformatf("D%0d", i);
      if (i <= 3)       expectReq(tag, 32'(4 * i));
      else if (i <= 10) expectNoReq(tag);
      else if (i <= 18) expectReq(tag, 32'(16 + 4 * (i - 11)));
      if (i < 2)        expectEmpty(tag);
      else if (i <= 9)  expectHead(tag, 32'h1000_0000, 32'h0, 32'h4);
      else if (i <= 17) expectHead(tag, 32'h1000_0000 + 32'(i - 10), 32'(4 * (i - 10)), 32'(4 * (i - 9)));
      case (i)
        18, 19: expectHead(tag, 32'h1000_0008, 32'h20, 32'h24);
        20: begin expectReq(tag, 32'h100); expectEmpty(tag); end
        21: begin expectReq(tag, 32'h104); expectEmpty(tag); end
        22: begin expectReq(tag, 32'h108); expectHead(tag, 32'h1000_0040, 32'h100, 32'h104); end
        23: begin expectReq(tag, 32'h10C); expectHead(tag, 32'h1000_0041, 32'h104, 32'h108); end
        24: begin expectNoReq(tag); expectHead(tag, 32'h1000_0042, 32'h108, 32'h10C); end
        25: begin expectReq(tag, 32'h200); expectEmpty(tag); end
        26: begin expectReq(tag, 32'h204); expectEmpty(tag); end
        27: begin expectReq(tag, 32'h208); expectHead(tag, 32'h1000_0080, 32'h200, 32'h204); end
        28: begin expectReq(tag, 32'h20C); expectHead(tag, 32'h1000_0080, 32'h200, 32'h204); end
        29, 30: begin expectNoReq(tag); expectHead(tag, 32'h1000_0080, 32'h200, 32'h204); end
        default: ;
      endcase
      if (i == 19) expectNoReq(tag);
`ifdef FETCH_PERF_COUNTERS_EN
      if (i == 0) begin
        checkOutput({tag, "_stall"}, stallCycles, 32'd0);
        checkOutput({tag, "_flush"}, flushCount, 32'd0);
      end
      if (i == 10) checkOutput({tag, "_stall"}, stallCycles, 32'd8);
      if (i == 20) begin
        checkOutput({tag, "_stall"}, stallCycles, 32'd10);
        checkOutput({tag, "_flush"}, flushCount, 32'd1);
      end
      if (i == 25) begin
        checkOutput({tag, "_stall"}, stallCycles, 32'd10);
        checkOutput({tag, "_flush"}, flushCount, 32'd2);
      end
`endif
    end

    // Asynchronous reset in the middle of a cycle with the FIFO full.
    Rst = 1'b0;
    #1;
    expectNoReq("async");
    expectEmpty("async");
    checkOutput("async_instr", Instruction, 32'd0);
    checkOutput("async_pc", InstrPC, 32'd0);
    checkOutput("async_pc4", InstrPCPlus4, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput("async_stall", stallCycles, 32'd0);
    checkOutput("async_flush", flushCount, 32'd0);
`endif

    // Fetch restarts at RESET_PC after release.
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (i == 0) Rst = 1'b1;
      InstrReady = 1'b1;
      Redirect   = 1'b0;
      #1;
      tag = $sformatf("F%0d", i);
      expectReq(tag, 32'(4 * i));
      if (i < 2) expectEmpty(tag);
      else expectHead(tag, 32'h1000_0000 + 32'(i - 2), 32'(4 * (i - 2)), 32'(4 * (i - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the controller/ALU datapath.
- Owns the program counter and issues word reads to a synchronous instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to the controller's Instruction input with a valid/ready handshake.
- Redirects on a taken branch (PCSrc plus target) and flushes all wrong-path words.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- IMemReq  output  1  read request to instruction memory; always accepted.
- IMemAddr  output  32  byte address of the request; bits [1:0] always 0.
- IMemRdata  input  32  read data, valid exactly one cycle after the request cycle.
- Redirect  input  1  taken branch/jump (controller PCSrc).
- RedirectTarget  input  32  new PC; bits [1:0] ignored and treated as 0.
- Instruction  output  32  head-of-FIFO instruction word.
- InstrPC  output  32  address of Instruction.
- InstrPCPlus4  output  32  InstrPC + 4, modulo 2^32.
- InstrValid  output  1  Instruction, InstrPC and InstrPCPlus4 are valid.
- InstrReady  input  1  downstream accepts the head entry this cycle.

Behaviour:
- Reset (Rst=0, asynchronous):
  - PC = RESET_PC; FIFO empty; in-flight flag clear.
  - IMemReq = 0, InstrValid = 0, Instruction/InstrPC/InstrPCPlus4 = 0.
- State per cycle: PC register, FIFO count (0..DEPTH), inflight bit (a request was issued in the previous cycle).
- Issue rule:
  - IMemReq = 1 when Redirect = 0 and count + inflight < DEPTH, using registered values only. A same-cycle pop does not free credit until the next cycle.
  - On issue: IMemAddr = PC, and PC <= PC + 4 (wraps 32'hFFFF_FFFC -> 32'h0).
- Response:
  - If inflight = 1 and no redirect occurred since that request, IMemRdata is written to the FIFO tail at the end of the cycle, tagged with the request address.
  - Never overflows, by the credit rule.
- Pop: when InstrValid = 1 and InstrReady = 1, the head is removed at the clock edge.
  - Push and pop in the same cycle leave count unchanged.
  - Outputs are driven from registered FIFO state; there is no memory-to-output bypass.
- InstrValid = (count != 0). Head fields are held stable while InstrValid = 1 and InstrReady = 0.
- Redirect (highest priority):
  - Same edge: PC <= {RedirectTarget[31:2], 2'b00}; FIFO count <= 0.
  - Any outstanding response is discarded, tracked with an epoch bit or an inflight kill.
  - No request is issued in the redirect cycle.
  - A pop coincident with Redirect is still considered consumed by downstream; the FIFO is cleared regardless.
- Latency:
  - Redirect in cycle N -> IMemReq at target in N+1 -> data captured at the end of N+2 -> InstrValid in N+3.
  - First fetch after reset release follows the same timing, starting from the first cycle after Rst rises.
- Throughput: with DEPTH >= 3 and InstrReady held at 1, one instruction per cycle is sustained.
- Reset asserted mid-operation: immediate return to the reset state; in-flight data is dropped.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- When defined, two extra outputs are added:
  - StallCycles[31:0]: increments each cycle InstrValid = 1 and InstrReady = 0.
  - FlushCount[31:0]: increments on each Redirect cycle.
  - Both are cleared by reset and wrap at 2^32.
- When undefined, neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC = 0 and memory word[i] = 32'h1000_0000 + i; InstrReady held at 1:
  - IMemAddr sequence is 0, 4, 8, ….
  - InstrValid first rises 2 cycles after the first IMemReq.
  - Instructions 32'h1000_0000, 32'h1000_0001, … arrive on consecutive cycles with InstrPC 0, 4, 8.
- InstrReady held at 0 for 10 cycles:
  - Exactly DEPTH = 4 entries are buffered, then IMemReq drops to 0.
  - Head stays at InstrPC = 0 throughout.
  - After InstrReady returns to 1, words 0..7 drain in order with no gaps and no duplicates.
- Redirect to 32'h0000_0103 while the FIFO holds 3 entries and a request is in flight:
  - Next IMemAddr = 32'h0000_0100.
  - Stale entries never appear on Instruction.
  - InstrValid returns 3 cycles after Redirect with InstrPC = 32'h100.
- PC wrap with RESET_PC = 32'hFFFF_FFF8:
  - Fetch addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - InstrPCPlus4 of the FFFF_FFFC entry is 0.
- Rst pulled low asynchronously mid-stream with the FIFO full:
  - InstrValid and IMemReq go to 0 before the next edge.
  - After release, fetch restarts at RESET_PC.
- With FETCH_PERF_COUNTERS_EN defined:
  - 5 stall cycles and 2 redirects give StallCycles = 5 and FlushCount = 2.
  - Both read 0 after reset.
